// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO registers.
// Accepts mult/multu/div/divu through a start/busy handshake and commits the
// result after a fixed number of busy cycles. mthi/mtlo write HI/LO directly.
// Optional feature macro: MDU_DIV_EN enables div/divu. Without it, ops 3 and 4
// act as no-ops and no divider logic is built.
module mdu_iter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_p0;
  logic [31:0]      b_p0;
  logic [2:0]       op_p0;

  logic             launch_mul;
  logic             launch_div;
  logic             res_we;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic [63:0]      res_full;

  // Full 64-bit product; operands are sign- or zero-extended before multiplying.
  function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ax * bx;
  endfunction

`ifdef MDU_DIV_EN
  // Returns {remainder, quotient}. The lone signed overflow case is pinned
  // explicitly; the divisor is never zero when this result is committed.
  function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        q;
    logic [31:0]        r;
    sa = a;
    sb = b;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction
`endif

  assign busy       = (state == S_BUSY);
  assign launch_mul = start && !busy && (op == OP_MULT || op == OP_MULTU);
`ifdef MDU_DIV_EN
  assign launch_div = start && !busy && (op == OP_DIV || op == OP_DIVU);
`else
  assign launch_div = 1'b0;
`endif

  // Result of the captured operation, committed on the final busy edge.
  always_comb begin
    res_we   = 1'b0;
    res_full = 64'h0;
    case (op_p0)
      OP_MULT, OP_MULTU: begin
        res_full = mul_full(a_p0, b_p0, op_p0 == OP_MULT);
        res_we   = 1'b1;
      end
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        res_full = div_full(a_p0, b_p0, op_p0 == OP_DIV);
        res_we   = (b_p0 != 32'h0);
      end
`endif
      default: ;
    endcase
    res_hi = res_full[63:32];
    res_lo = res_full[31:0];
  end

  // Control FSM, operand capture (stage p0), and HI/LO architectural state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch_mul || launch_div) begin
            a_p0  <= A;
            b_p0  <= B;
            op_p0 <= op;
            cnt   <= launch_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state <= S_BUSY;
          end else if (start && op == OP_MTHI) begin
            HI <= A;
          end else if (start && op == OP_MTLO) begin
            LO <= A;
          end
        end
        default: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            if (res_we) begin
              HI <= res_hi;
              LO <= res_lo;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter (default build; MDU_DIV_EN selects the
// divider scenarios or the divider-disabled scenario).
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  mdu_iter #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Present one start for a single edge; returns at the negedge after that edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  // Counts remaining busy cycles (sampled at negedges), bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int c;
    reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL rst_hi got=%h exp=0", HI); end
    total++; if (LO !== 32'h0) begin bad++; $display("FAIL rst_lo got=%h exp=0", LO); end
    reset = 1'b0;
    issue(3'd1, 32'd7, 32'd6);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL midrst_hi got=%h exp=0", HI); end
    total++; if (LO !== 32'h0) begin bad++; $display("FAIL midrst_lo got=%h exp=0", LO); end
    @(negedge clk);
    reset = 1'b0;
    c = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) c++;
    end
    total++; if (c !== 0) begin bad++; $display("FAIL midrst_nobusy got=%0d exp=0", c); end
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL midrst_hi_late got=%h exp=0", HI); end
    total++; if (LO !== 32'h0) begin bad++; $display("FAIL midrst_lo_late got=%h exp=0", LO); end
  endtask

  task automatic test_multu;
    int c;
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(c);
    total++; if (c !== 5) begin bad++; $display("FAIL multu_cycles got=%0d exp=5", c); end
    total++; if (HI !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", HI); end
    total++; if (LO !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", LO); end
  endtask

  task automatic test_mult_signed;
    int c;
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    wait_idle(c);
    total++; if (c !== 5) begin bad++; $display("FAIL mult_cycles got=%0d exp=5", c); end
    total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    total++; if (LO !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo got=%h exp=fffffff1", LO); end
  endtask

  task automatic test_mthi_mtlo;
    issue(3'd5, 32'h11, 32'h0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    total++; if (HI !== 32'h11) begin bad++; $display("FAIL mthi_hi got=%h exp=11", HI); end
    issue(3'd6, 32'h22, 32'h0);
    total++; if (LO !== 32'h22) begin bad++; $display("FAIL mtlo_lo got=%h exp=22", LO); end
    total++; if (HI !== 32'h11) begin bad++; $display("FAIL mtlo_hi_kept got=%h exp=11", HI); end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div;
    int c;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(c);
    total++; if (c !== 10) begin bad++; $display("FAIL div_cycles got=%0d exp=10", c); end
    total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(c);
    total++; if (LO !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo got=%h exp=80000000", LO); end
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL divovf_hi got=%h exp=0", HI); end
    issue(3'd5, 32'h11, 32'h0);
    issue(3'd6, 32'h22, 32'h0);
    issue(3'd4, 32'd9, 32'd0);
    start = 1'b1; op = 3'd5; A = 32'h55;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(c);
    total++; if (c !== 9) begin bad++; $display("FAIL div0_cycles got=%0d exp=9", c); end
    total++; if (HI !== 32'h11) begin bad++; $display("FAIL div0_hi got=%h exp=11", HI); end
    total++; if (LO !== 32'h22) begin bad++; $display("FAIL div0_lo got=%h exp=22", LO); end
  endtask
`else
  task automatic test_div;
    int c;
    issue(3'd4, 32'd8, 32'd2);
    c = 0;
    repeat (4) begin
      if (busy) c++;
      @(negedge clk);
    end
    total++; if (c !== 0) begin bad++; $display("FAIL divoff_busy got=%0d exp=0", c); end
    total++; if (HI !== 32'h11) begin bad++; $display("FAIL divoff_hi got=%h exp=11", HI); end
    total++; if (LO !== 32'h22) begin bad++; $display("FAIL divoff_lo got=%h exp=22", LO); end
  endtask
`endif

  task automatic test_busy_ignore;
    int c;
    issue(3'd1, 32'd2, 32'd3);
    start = 1'b1; op = 3'd5; A = 32'h55; B = 32'h0;
    @(negedge clk);
    op = 3'd2; A = 32'd100; B = 32'd100;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(c);
    total++; if (c !== 3) begin bad++; $display("FAIL ign_cycles got=%0d exp=3", c); end
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL ign_hi got=%h exp=0", HI); end
    total++; if (LO !== 32'd6) begin bad++; $display("FAIL ign_lo got=%h exp=6", LO); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_norelaunch got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int c;
    issue(3'd1, 32'd21, 32'd12);
    wait_idle(c);
    total++; if (c !== 5) begin bad++; $display("FAIL b2b_cycles1 got=%0d exp=5", c); end
    total++; if (LO !== 32'd252) begin bad++; $display("FAIL b2b_lo1 got=%0d exp=252", LO); end
    start = 1'b1; op = 3'd2; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_idle(c);
    total++; if (c !== 5) begin bad++; $display("FAIL b2b_cycles2 got=%0d exp=5", c); end
    total++; if (LO !== 32'd12) begin bad++; $display("FAIL b2b_lo2 got=%0d exp=12", LO); end
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL b2b_hi2 got=%h exp=0", HI); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult_signed;
    test_mthi_mtlo;
    test_div;
    test_busy_ignore;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the MIPS32 pipeline's EX stage, beside the combinational ALU. It accepts `mult/multu/div/divu` operations with a start/busy handshake and holds results in architectural HI/LO registers. It also services `mthi/mtlo` writes and continuously drives HI/LO for `mfhi/mflo`. The hazard unit stalls on `busy | start`.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for multiply.
- `DIV_CYCLES`, default 10: busy cycles for divide.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: launch the operation in `op`. Sampled only when `busy`=0.
- `op` in 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- `A` in 32: operand rs / dividend / mthi-mtlo data.
- `B` in 32: operand rt / divisor.
- `busy` out 1: operation in flight.
- `HI` out 32: HI register.
- `LO` out 32: LO register.

## Operation
- Reset: `busy`=0, `HI`=0, `LO`=0, counter=0, shadow registers=0. Reset mid-operation aborts the operation; no result is committed.
- Idle, `start`=1, op ∈ {1..4}:
  - Capture `A`, `B`, and `op`.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to BUSY.
- Idle, `start`=1, op 5 or 6: write `A` to HI (5) or LO (6) at that edge. No busy cycle.
- Ops 0 and 7: no effect.
- States:
  - IDLE → BUSY on a multiply/divide start.
  - BUSY: decrement the counter each edge. When the counter reaches 1, the next edge commits the result and returns to IDLE.
- Arithmetic:
  - mult: signed 32×32 → 64. HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder, carrying the dividend's sign.
  - divu: unsigned quotient and remainder.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero: the operation runs its full `DIV_CYCLES`, and HI/LO are left unchanged.
- Results are computed from the captured operands. Changes on `A`/`B`/`op` during BUSY have no effect.
- `start` during BUSY is ignored, including mthi/mtlo. The stall logic must hold the instruction and re-present it.

## Timing
- Start edge E0: `busy` rises after E0.
- Commit edge: HI/LO update and `busy` falls after E0+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- `busy` is high for exactly N cycles.
- A new `start` is accepted in the first cycle `busy`=0, giving back-to-back throughput of one op per N+1 cycles.
- HI/LO are registered outputs. A value written by mthi/mtlo at edge E is visible after E, with no combinational bypass from `A`.
- `busy` is registered and has no combinational path from `start`.

## Configuration
- `MDU_DIV_EN`
  - Defined: div/divu are implemented as specified above.
  - Undefined: ops 3 and 4 behave as op 0 (no busy, HI/LO unchanged), and no divider logic is synthesized.
- Multiply and mthi/mtlo are unaffected by the macro.

## Test plan
- Reset mid-op: mult 7×6, assert `reset` at the 3rd busy cycle → `busy`=0, HI=LO=0 immediately, and nothing is committed later.
- multu 0xFFFFFFFF×0xFFFFFFFF → `busy` high 5 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- mult -3×5 (A=0xFFFFFFFD, B=5) → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div -7/2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero and busy-time ignores:
  - Preset HI=0x11, LO=0x22 via mthi/mtlo.
  - divu 9/0 → HI/LO unchanged after 10 cycles.
  - mthi 0x55 pulsed during BUSY → HI stays 0x11.
- Back-to-back: mult 21×12 followed immediately by multu 3×4 at the first idle cycle → LO=252, then LO=12. With `MDU_DIV_EN` undefined, divu 8/2 → `busy` never rises and HI/LO are unchanged.
